// File: rtl/alu_pkg.sv
// Shared opcodes, flag indices and FSM state type for the execute-stage ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_NOTA = 3'd2;
   localparam logic [2:0] OP_NOTB = 3'd3;
   localparam logic [2:0] OP_OR   = 3'd4;
   localparam logic [2:0] OP_ORN  = 3'd5;
   localparam logic [2:0] OP_AND  = 3'd6;
   localparam logic [2:0] OP_ANDN = 3'd7;

   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_ROL = 4'b1011;

   localparam int FLG_Z = 0;
   localparam int FLG_N = 1;
   localparam int FLG_C = 2;
   localparam int FLG_V = 3;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit function table with carry and signed-overflow outputs.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow
);

   logic [WIDTH-1:0] b_sel;
   logic [WIDTH:0]   sum;

   // op 1 is a+~b+cin, so the same adder serves both arithmetic ops.
   assign b_sel = op[0] ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, b_sel} + {{WIDTH{1'b0}}, cin};

   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            result   = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            overflow = (a[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_NOTA: result = ~a;
         OP_NOTB: result = ~b;
         OP_OR:   result = a | b;
         OP_ORN:  result = a | ~b;
         OP_AND:  result = a & b;
         OP_ANDN: result = a & ~b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready handshake and {V,C,N,Z} flags.
// Define ALU_SHIFT_EN to add the bit-serial shifter selected by op[3].
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] core_res;
   logic             core_c;
   logic             core_v;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op       (op[2:0]),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .result   (core_res),
      .carry    (core_c),
      .overflow (core_v)
   );

   logic             out_valid_reg;
   logic [WIDTH-1:0] result_reg;
   logic [3:0]       flags_reg;
   logic             busy;
   logic             accept;
   logic             wr_en;
   logic [WIDTH-1:0] wr_res;
   logic             wr_c;
   logic             wr_v;
   logic [3:0]       flags_next;

   assign in_ready = !busy && (!out_valid_reg || out_ready);
   assign accept   = in_valid && in_ready;

`ifdef ALU_SHIFT_EN
   state_t           state_reg;
   logic [SHW-1:0]   cnt_reg;
   logic [WIDTH-1:0] sh_reg;
   logic [1:0]       sh_op_reg;
   logic             sh_c_reg;
   logic [WIDTH-1:0] sh_next;
   logic             sh_c_next;
   logic [SHW-1:0]   k;

   assign k    = b[SHW-1:0];
   assign busy = (state_reg == ST_SHIFT);

   always_comb begin
      sh_next   = sh_reg;
      sh_c_next = sh_c_reg;
      case ({2'b10, sh_op_reg})
         OP_SLL: begin sh_next = {sh_reg[WIDTH-2:0], 1'b0};          sh_c_next = sh_reg[WIDTH-1]; end
         OP_SRL: begin sh_next = {1'b0, sh_reg[WIDTH-1:1]};          sh_c_next = sh_reg[0];       end
         OP_SRA: begin sh_next = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]}; sh_c_next = sh_reg[0];     end
         OP_ROL: begin sh_next = {sh_reg[WIDTH-2:0], sh_reg[WIDTH-1]}; sh_c_next = sh_reg[WIDTH-1]; end
         default: ;
      endcase
   end

   always_comb begin
      wr_en  = 1'b0;
      wr_res = core_res;
      wr_c   = core_c;
      wr_v   = core_v;
      if (state_reg == ST_SHIFT) begin
         if (cnt_reg == '0) begin
            wr_en  = 1'b1;
            wr_res = sh_reg;
            wr_c   = sh_c_reg;
            wr_v   = 1'b0;
         end
      end else if (accept) begin
         if (!op[3]) begin
            wr_en = 1'b1;
         end else if (k == '0) begin
            wr_en  = 1'b1;
            wr_res = a;
            wr_c   = 1'b0;
            wr_v   = 1'b0;
         end
      end
   end

   // One bit per cycle; the extra cycle at cnt==0 commits to the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         sh_reg    <= '0;
         sh_op_reg <= '0;
         sh_c_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept && op[3] && (k != '0)) begin
                  state_reg <= ST_SHIFT;
                  cnt_reg   <= k;
                  sh_reg    <= a;
                  sh_op_reg <= op[1:0];
                  sh_c_reg  <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (cnt_reg == '0) begin
                  state_reg <= ST_IDLE;
               end else begin
                  sh_reg   <= sh_next;
                  sh_c_reg <= sh_c_next;
                  cnt_reg  <= cnt_reg - 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end
`else
   logic unused_op3;

   assign unused_op3 = op[3];
   assign busy       = 1'b0;
   assign wr_en      = accept;
   assign wr_res     = core_res;
   assign wr_c       = core_c;
   assign wr_v       = core_v;
`endif

   always_comb begin
      flags_next        = '0;
      flags_next[FLG_Z] = (wr_res == '0);
      flags_next[FLG_N] = wr_res[WIDTH-1];
      flags_next[FLG_C] = wr_c;
      flags_next[FLG_V] = wr_v;
   end

   // A new write wins over a simultaneous downstream take, keeping out_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         flags_reg     <= '0;
      end else if (wr_en) begin
         out_valid_reg <= 1'b1;
         result_reg    <= wr_res;
         flags_reg     <= flags_next;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed, table-driven bench for alu_pipe (WIDTH=16); shift cases need ALU_SHIFT_EN.
module tb_alu_pipe;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [3:0]  flags;

   int total  = 0;
   int passed = 0;

   alu_pipe #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] exp_res;
      logic [3:0]  exp_flg;   // {V,C,N,Z}
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb,
                        input logic c);
      in_valid = 1'b1;
      op = o; a = aa; b = bb; cin = c;
   endtask

`ifdef ALU_SHIFT_EN
   task automatic do_shift(input string name, input logic [3:0] o, input logic [15:0] aa,
                           input logic [15:0] bb, input logic [15:0] er, input logic [3:0] ef);
      int lat;
      @(negedge clk);
      drive(o, aa, bb, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      if (bb[3:0] != 4'd0) chk({name, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, lat, {28'd0, bb[3:0]} + 32'd1);
      chk({name, "_result"}, {16'd0, result}, {16'd0, er});
      chk({name, "_flags"}, {28'd0, flags}, {28'd0, ef});
      $display("shift %s op=%h a=%h k=%0d -> %h flags=%b latency=%0d", name, o, aa, bb[3:0],
               result, flags, lat);
   endtask
`endif

   initial begin
      int stale;
      vecs[0]  = '{4'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1010};
      vecs[1]  = '{4'd1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 4'b0100};
      vecs[2]  = '{4'd1, 16'h0003, 16'h0003, 1'b1, 16'h0000, 4'b0101};
      vecs[3]  = '{4'd7, 16'hFFFF, 16'h00F0, 1'b0, 16'hFF0F, 4'b0010};
      vecs[4]  = '{4'd2, 16'hFFFF, 16'h1234, 1'b0, 16'h0000, 4'b0001};
      vecs[5]  = '{4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0101};
      vecs[6]  = '{4'd0, 16'h0002, 16'h0003, 1'b1, 16'h0006, 4'b0000};
      vecs[7]  = '{4'd3, 16'h5555, 16'h0000, 1'b0, 16'hFFFF, 4'b0010};
      vecs[8]  = '{4'd4, 16'h1200, 16'h0034, 1'b1, 16'h1234, 4'b0000};
      vecs[9]  = '{4'd5, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 4'b0001};
      vecs[10] = '{4'd6, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 4'b0010};
      vecs[11] = '{4'd1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1100};
      vecs[12] = '{4'd0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b1101};
      vecs[13] = '{4'd1, 16'h0005, 16'h0003, 1'b0, 16'h0001, 4'b0100};
      vecs[14] = '{4'd5, 16'h00F0, 16'hFF0F, 1'b0, 16'h00F0, 4'b0000};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; a = '0; b = '0; cin = 1'b0;
      #1;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_result", {16'd0, result}, 32'd0);
      chk("reset_flags", {28'd0, flags}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

      // Back-to-back: one op per cycle, each result checked one cycle after accept.
      for (int i = 0; i <= NV; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk($sformatf("v%0d_out_valid", i-1), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_result", i-1), {16'd0, result}, {16'd0, vecs[i-1].exp_res});
            chk($sformatf("v%0d_flags", i-1), {28'd0, flags}, {28'd0, vecs[i-1].exp_flg});
            $display("vec %0d op=%0d a=%h b=%h cin=%b -> %h flags=%b", i-1, vecs[i-1].op,
                     vecs[i-1].a, vecs[i-1].b, vecs[i-1].cin, result, flags);
         end
         if (i < NV) begin
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

      // Backpressure: result held, new op stalled, accepted on release.
      out_ready = 1'b0;
      drive(4'd0, 16'h0002, 16'h0003, 1'b0);
      @(negedge clk);
      drive(4'd0, 16'h0010, 16'h0001, 1'b0);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("bp%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp%0d_result", c), {16'd0, result}, 32'h0005);
         chk($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_next_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_next_result", {16'd0, result}, 32'h0011);
      $display("backpressure release -> %h flags=%b", result, flags);
      @(negedge clk);

`ifdef ALU_SHIFT_EN
      do_shift("sll4",  OP_SLL, 16'h8001, 16'h0004, 16'h0010, 4'b0000);
      do_shift("sra15", OP_SRA, 16'h8000, 16'h000F, 16'hFFFF, 4'b0010);
      do_shift("rol1",  OP_ROL, 16'h8001, 16'h0001, 16'h0003, 4'b0100);
      do_shift("srl1",  OP_SRL, 16'h0001, 16'h0001, 16'h0000, 4'b0101);
      do_shift("sll0",  OP_SLL, 16'h8001, 16'h0000, 16'h8001, 4'b0010);
      // Reset two cycles into an 8-step shift: nothing partial may appear.
      @(negedge clk);
      drive(OP_SLL, 16'h00FF, 16'h0008, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
`else
      // Reset while a result is held under backpressure.
      out_ready = 1'b0;
      drive(4'd0, 16'h0001, 16'h0001, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
`endif
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_result", {16'd0, result}, 32'd0);
      chk("midrst_flags", {28'd0, flags}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      stale = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("midrst_no_stale", stale, 32'd0);
      $display("reset mid-operation: stale outputs=%0d", stale);

      drive(4'd0, 16'h1111, 16'h2222, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("post_rst_result", {16'd0, result}, 32'h3334);
      chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
